gray_count_receiver: RTL and testbench

Destination-side companion to the gray counter: samples a Gray-coded count driven from a foreign clock domain, synchronizes it through a flop chain, decodes it to binary and reports how far the count advanced each cycle. Sits at the read or write side of the async FIFO, or any CDC event counter, so local logic sees a clean binary pointer and a per-cycle increment.

---
 rtl/gray_code_pkg.sv | 22 ++
 rtl/cdc_sync_bus.sv | 21 ++
 rtl/gray_count_receiver.sv | 72 +++++++
 tb/tb_gray_count_receiver.sv | 116 +++++++++++
 4 files changed

// File: rtl/gray_code_pkg.sv
// gray_code_pkg: shared Gray-code helpers and constants for the gray counter and its receiver.
//   GRAY_SYNC_STAGES : default synchronizer depth shared by source and destination sides
//   GRAY_MAX_W       : widest count the helper functions support
//   gray2bin(g, w)   : decode the low w bits of g from Gray to binary
//   bin2gray(b, w)   : encode the low w bits of b from binary to Gray
package gray_code_pkg;
   localparam int GRAY_SYNC_STAGES = 2;
   localparam int GRAY_MAX_W = 32;
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g, input int w);
      logic [GRAY_MAX_W-1:0] b;
      b = '0;
      b[w-1] = g[w-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--)
         if (i < w-1) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b, input int w);
      logic [GRAY_MAX_W-1:0] m;
      m = {GRAY_MAX_W{1'b1}} >> (GRAY_MAX_W - w);
      return (b ^ (b >> 1)) & m;
   endfunction
endpackage

// File: rtl/cdc_sync_bus.sv
// cdc_sync_bus: WIDTH-bit, STAGES-deep flop chain for bringing a Gray bus into the local clock domain.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears every stage
//   d_i    : bus from the foreign domain, sampled by stage 0
//   q_o    : output of the last stage
module cdc_sync_bus #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= '0;
      else sync_q <= {sync_q[STAGES-2:0], d_i};
   end
   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/gray_count_receiver.sv
// gray_count_receiver: synchronizes a foreign-domain Gray count, decodes it and reports the per-cycle advance.
//   Clk             : destination clock
//   Reset_n         : asynchronous active-low reset, all flops to 0
//   GrayCount_in    : Gray count from the source domain
//   Clear_in        : synchronous re-baseline; zeroes delta/advance/error, keeps the count
//   BinaryCount_out : registered decoded count
//   Delta_out       : advance since the previous cycle, modulo 2^COUNTER_WIDTH
//   Advance_out     : Delta_out is non-zero
//   StepError_out   : sticky flag for an advance above MAX_STEP, only with GRAY_RX_STEP_CHECK_EN
module gray_count_receiver
   import gray_code_pkg::*;
#(
   parameter int COUNTER_WIDTH = 4,
   parameter int SYNC_STAGES   = GRAY_SYNC_STAGES,
   parameter int MAX_STEP      = 1
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic [COUNTER_WIDTH-1:0] GrayCount_in,
   input  logic                     Clear_in,
   output logic [COUNTER_WIDTH-1:0] BinaryCount_out,
   output logic [COUNTER_WIDTH-1:0] Delta_out,
   output logic                     Advance_out
`ifdef GRAY_RX_STEP_CHECK_EN
   ,
   output logic                     StepError_out
`endif
);
   if (COUNTER_WIDTH < 2 || COUNTER_WIDTH > GRAY_MAX_W || SYNC_STAGES < 2 || MAX_STEP < 1) begin : g_bad_cfg
      $error("gray_count_receiver: unsupported parameter combination");
   end
   logic [COUNTER_WIDTH-1:0] sync_gray, dec, raw_delta;
   logic [COUNTER_WIDTH-1:0] bin_q, bin_d, delta_q, delta_d;
   logic                     adv_q, adv_d;
   cdc_sync_bus #(.WIDTH(COUNTER_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (Clk),
      .rst_ni (Reset_n),
      .d_i    (GrayCount_in),
      .q_o    (sync_gray)
   );
   assign dec = COUNTER_WIDTH'(gray2bin(GRAY_MAX_W'(sync_gray), COUNTER_WIDTH));
   // modulo subtraction makes a wrap from all-ones to zero read as a step of one
   assign raw_delta = dec - bin_q;
   always_comb begin
      bin_d   = dec;
      delta_d = Clear_in ? '0 : raw_delta;
      adv_d   = !Clear_in && (raw_delta != '0);
   end
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         bin_q   <= '0;
         delta_q <= '0;
         adv_q   <= 1'b0;
      end else begin
         bin_q   <= bin_d;
         delta_q <= delta_d;
         adv_q   <= adv_d;
      end
   end
   assign BinaryCount_out = bin_q;
   assign Delta_out       = delta_q;
   assign Advance_out     = adv_q;
`ifdef GRAY_RX_STEP_CHECK_EN
   logic err_q, err_d;
   assign err_d = Clear_in ? 1'b0 : (err_q | (int'(raw_delta) > MAX_STEP));
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) err_q <= 1'b0;
      else err_q <= err_d;
   end
   assign StepError_out = err_q;
`endif
endmodule

// File: tb/tb_gray_count_receiver.sv
// tb_gray_count_receiver: directed scoreboard bench for gray_count_receiver (W=4, 2 sync stages, MAX_STEP=1).
module tb_gray_count_receiver;
   localparam int W = 4;
   localparam int MS = 1;
   logic         Clk, Reset_n, Clear_in;
   logic [W-1:0] GrayCount_in, BinaryCount_out, Delta_out;
   logic         Advance_out;
   logic         StepError_out;
   int           checks = 0, failures = 0;
   logic [W-1:0] pipe[$];
   logic [W-1:0] e_bin, e_delta;
   logic         e_adv, e_err;
   gray_count_receiver #(.COUNTER_WIDTH(W), .SYNC_STAGES(2), .MAX_STEP(MS)) dut (
      .Clk             (Clk),
      .Reset_n         (Reset_n),
      .GrayCount_in    (GrayCount_in),
      .Clear_in        (Clear_in),
      .BinaryCount_out (BinaryCount_out),
      .Delta_out       (Delta_out),
      .Advance_out     (Advance_out)
`ifdef GRAY_RX_STEP_CHECK_EN
      ,
      .StepError_out   (StepError_out)
`endif
   );
`ifndef GRAY_RX_STEP_CHECK_EN
   assign StepError_out = 1'b0;
`endif
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end
   function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
      logic [W-1:0] b;
      b = g;
      for (int s = 1; s < W; s = s * 2) b = b ^ (b >> s);
      return b;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic chk_all(input string tag);
      chk({tag, ".bin"}, 32'(BinaryCount_out), 32'(e_bin));
      chk({tag, ".delta"}, 32'(Delta_out), 32'(e_delta));
      chk({tag, ".adv"}, 32'(Advance_out), 32'(e_adv));
`ifdef GRAY_RX_STEP_CHECK_EN
      chk({tag, ".err"}, 32'(StepError_out), 32'(e_err));
`endif
   endtask
   task automatic model_reset();
      pipe.delete();
      pipe.push_back('0);
      pipe.push_back('0);
      e_bin = '0;
      e_delta = '0;
      e_adv = 1'b0;
      e_err = 1'b0;
   endtask
   task automatic cyc(input string tag, input logic [W-1:0] g, input logic c);
      logic [W-1:0] nb, d;
      @(negedge Clk);
      GrayCount_in = g;
      Clear_in = c;
      pipe.push_back(g2b(g));
      @(posedge Clk);
      nb = pipe.pop_front();
      d = nb - e_bin;
      e_delta = c ? '0 : d;
      e_adv = !c && (d != '0);
      e_err = c ? 1'b0 : (e_err || (int'(d) > MS));
      e_bin = nb;
      #1 chk_all(tag);
   endtask
   task automatic hold(input string tag, input logic [W-1:0] g, input int n);
      for (int i = 0; i < n; i++) cyc(tag, g, 1'b0);
   endtask
   initial begin
      Reset_n = 1'b0;
      Clear_in = 1'b0;
      GrayCount_in = 4'b0110;
      model_reset();
      repeat (3) @(posedge Clk);
      #2 chk_all("reset_hold");
      Reset_n = 1'b1;
      hold("release", 4'b0110, 4);
      cyc("clr0", 4'b0110, 1'b1);
      hold("step0", 4'b0000, 4);
      cyc("clr1", 4'b0000, 1'b1);
      hold("step1", 4'b0001, 4);
      hold("step2", 4'b0011, 4);
      hold("step3", 4'b0010, 4);
      hold("wrap14", 4'b1001, 4);
      hold("wrap15", 4'b1000, 4);
      hold("wrap0", 4'b0000, 4);
      cyc("clr2", 4'b0000, 1'b1);
      hold("multi1", 4'b0001, 4);
      hold("multi4", 4'b0110, 4);
      hold("to9", 4'b1101, 4);
      cyc("clear9", 4'b1101, 1'b1);
      hold("after_clear", 4'b1101, 2);
      hold("pre_arst", 4'b0111, 3);
      #2 Reset_n = 1'b0;
      model_reset();
      #1 chk_all("async_reset");
      repeat (2) @(posedge Clk);
      #2 chk_all("async_hold");
      Reset_n = 1'b1;
      hold("post_arst", 4'b0111, 4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
